// File: rtl/poly_split.sv
// Polyphase splitter: pairs even/odd samples of a framed stream into a small
// FIFO, closing odd-length frames by duplicating the last even sample.
module poly_split #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [DATA_W-1:0]          m_even,
    output logic [DATA_W-1:0]          m_odd,
    output logic                       m_last,
    output logic                       m_pad,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 2 * DATA_W + 2;

    localparam logic [0:0]    PH_EVEN = 1'b0;
    localparam logic [0:0]    PH_ODD  = 1'b1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [0:0]                 phase_q, phase_d;
    logic [DATA_W-1:0]          even_q, even_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][EW-1:0]   mem_q, mem_d;

    logic          full_s;
    logic          empty_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;

    // Full/empty from registered pointers only, so s_ready never depends on m_ready.
    assign full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign accept_s = s_valid && !full_s && !rst;
    assign pop_s    = m_ready && !empty_s;

    // Phase tracking and pair assembly; entry layout is {even, odd, last, pad}.
    always_comb begin
        phase_d = phase_q;
        even_d  = even_q;
        push_s  = 1'b0;
        entry_s = '0;
        if (accept_s) begin
            case (phase_q)
                PH_EVEN: begin
                    if (s_last) begin
                        push_s  = 1'b1;
                        entry_s = {s_data, s_data, 1'b1, 1'b1};
                    end else begin
                        even_d  = s_data;
                        phase_d = PH_ODD;
                    end
                end
                PH_ODD: begin
                    push_s  = 1'b1;
                    entry_s = {even_q, s_data, s_last, 1'b0};
                    phase_d = PH_EVEN;
                end
                default: begin
                    phase_d = PH_EVEN;
                end
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // FIFO storage and pointer advance.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry_s;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers; reset drops any half-collected pair and the FIFO contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_EVEN;
            even_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            even_q   <= even_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];
    assign m_even  = head_s[EW-1 -: DATA_W];
    assign m_odd   = head_s[DATA_W+1 -: DATA_W];
    assign m_last  = head_s[1];
    assign m_pad   = head_s[0];
    assign m_valid = !empty_s;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign s_ready = !full_s && !rst;

endmodule

// File: tb/tb_poly_split.sv
// Self-checking bench for poly_split: directed vector table, corner-case
// sequences and randomized traffic against a frame-index reference model.
module tb_poly_split;

    localparam int DW = 16;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid, s_last, s_ready;
    logic [DW-1:0] m_even, m_odd;
    logic          m_last, m_pad, m_valid, m_ready;
    logic [LW-1:0] level;

    logic [23:0]   w_s_data, w_m_even, w_m_odd;
    logic          w_s_valid, w_s_last, w_s_ready;
    logic          w_m_last, w_m_pad, w_m_valid, w_m_ready;
    logic [LW-1:0] w_level;

    always #5 clk = ~clk;

    poly_split #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_even(m_even), .m_odd(m_odd), .m_last(m_last), .m_pad(m_pad),
        .m_valid(m_valid), .m_ready(m_ready), .level(level)
    );

    poly_split #(.DATA_W(24), .DEPTH(D)) dut_w (
        .clk(clk), .rst(rst),
        .s_data(w_s_data), .s_valid(w_s_valid), .s_last(w_s_last), .s_ready(w_s_ready),
        .m_even(w_m_even), .m_odd(w_m_odd), .m_last(w_m_last), .m_pad(w_m_pad),
        .m_valid(w_m_valid), .m_ready(w_m_ready), .level(w_level)
    );

    typedef struct {
        logic [DW-1:0] e;
        logic [DW-1:0] o;
        logic          l;
        logic          p;
    } pair_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          push;
        logic [DW-1:0] e;
        logic [DW-1:0] o;
        logic          el;
        logic          ep;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    pair_t         mq[$];
    int            frame_idx = 0;
    logic [DW-1:0] held = '0;
    logic          acc;
    vec_t          tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sample position within the frame decides pairing.
    task automatic model_in(input logic [DW-1:0] d, input logic l);
        if (frame_idx % 2 == 0) begin
            if (l) mq.push_back('{e: d, o: d, l: 1'b1, p: 1'b1});
            else   held = d;
        end else begin
            mq.push_back('{e: held, o: d, l: l, p: 1'b0});
        end
        frame_idx = l ? 0 : frame_idx + 1;
    endtask

    task automatic model_reset();
        mq.delete();
        frame_idx = 0;
        held      = '0;
    endtask

    // One clock: check against the model at negedge, update it, end at posedge+1.
    task automatic step();
        pair_t h;
        @(negedge clk);
        chk("level", 32'(level), 32'(mq.size()));
        chk("s_ready", 32'(s_ready), 32'(mq.size() < D));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (m_valid && m_ready && mq.size() != 0) begin
            h = mq.pop_front();
            chk("head_even", 32'(m_even), 32'(h.e));
            chk("head_odd",  32'(m_odd),  32'(h.o));
            chk("head_last", 32'(m_last), 32'(h.l));
            chk("head_pad",  32'(m_pad),  32'(h.p));
        end
        acc = s_valid && s_ready;
        if (acc) model_in(s_data, s_last);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 30 && mq.size() != 0; c++) step();
        chk("drained", 32'(m_valid), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0]  = '{16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[1]  = '{16'h0002, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0};
        tv[2]  = '{16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[3]  = '{16'h0004, 1'b0, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0};
        tv[4]  = '{16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[5]  = '{16'h0006, 1'b0, 1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0};
        tv[6]  = '{16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[7]  = '{16'h0008, 1'b1, 1'b1, 16'h0007, 16'h0008, 1'b1, 1'b0};
        tv[8]  = '{16'h000A, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[9]  = '{16'h000B, 1'b0, 1'b1, 16'h000A, 16'h000B, 1'b0, 1'b0};
        tv[10] = '{16'h000C, 1'b1, 1'b1, 16'h000C, 16'h000C, 1'b1, 1'b1};
        tv[11] = '{16'h000D, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[12] = '{16'h000E, 1'b1, 1'b1, 16'h000D, 16'h000E, 1'b1, 1'b0};

        rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        w_s_data = '0; w_s_valid = 1'b0; w_s_last = 1'b0; w_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_even",  32'(m_even),  32'(0));
        chk("rst_m_odd",   32'(m_odd),   32'(0));
        chk("rst_m_last",  32'(m_last),  32'(0));
        chk("rst_m_pad",   32'(m_pad),   32'(0));
        chk("rst_level",   32'(level),   32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Even frame, odd frame and the following frame, back-to-back.
        for (int i = 0; i < 13; i++) begin
            s_valid = 1'b1;
            s_data  = tv[i].d;
            s_last  = tv[i].l;
            step();
            chk("tbl_valid", 32'(m_valid), 32'(tv[i].push));
            if (tv[i].push) begin
                chk("tbl_even", 32'(m_even), 32'(tv[i].e));
                chk("tbl_odd",  32'(m_odd),  32'(tv[i].o));
                chk("tbl_last", 32'(m_last), 32'(tv[i].el));
                chk("tbl_pad",  32'(m_pad),  32'(tv[i].ep));
            end
        end
        drain();

        // Backpressure: fill, stall, then release.
        m_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            s_valid = 1'b1;
            s_data  = 16'h0100 + 16'(n + 1);
            s_last  = (n == 9);
            if (c == 12) m_ready = 1'b1;
            step();
            n += int'(acc);
            if (c == 10) begin
                chk("bp_level",   32'(level),   32'(4));
                chk("bp_s_ready", 32'(s_ready), 32'(0));
            end
        end
        chk("bp_count", 32'(n), 32'(10));
        drain();

        // Simultaneous push and pop at level 2.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h0201 + 16'(i);
            s_last  = 1'b0;
            step();
        end
        chk("pp_level_before", 32'(level), 32'(2));
        m_ready = 1'b1;
        s_data  = 16'h0206;
        s_last  = 1'b1;
        step();
        chk("pp_level_after", 32'(level), 32'(2));
        chk("pp_head_even",   32'(m_even), 32'(16'h0203));
        drain();

        // Reset in the middle of a frame.
        s_valid = 1'b1;
        s_data  = 16'h1111;
        s_last  = 1'b0;
        step();
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_m_valid", 32'(m_valid), 32'(0));
        chk("mr_m_even",  32'(m_even),  32'(0));
        chk("mr_m_odd",   32'(m_odd),   32'(0));
        chk("mr_level",   32'(level),   32'(0));
        chk("mr_s_ready", 32'(s_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 16'h2222;
        s_last  = 1'b0;
        step();
        s_data  = 16'h3333;
        s_last  = 1'b1;
        step();
        s_valid = 1'b0;
        chk("mr_pair_valid", 32'(m_valid), 32'(1));
        chk("mr_pair_even",  32'(m_even),  32'(16'h2222));
        chk("mr_pair_odd",   32'(m_odd),   32'(16'h3333));
        chk("mr_pair_last",  32'(m_last),  32'(1));
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            s_last  = ($urandom_range(0, 4) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Wide instance, bit-exact pass-through.
        w_s_valid = 1'b1;
        w_s_data  = 24'hFFFFFF;
        w_s_last  = 1'b0;
        @(posedge clk);
        #1;
        w_s_data  = 24'h800000;
        w_s_last  = 1'b1;
        @(posedge clk);
        #1;
        w_s_valid = 1'b0;
        chk("w_valid", 32'(w_m_valid), 32'(1));
        chk("w_even",  32'(w_m_even),  32'(24'hFFFFFF));
        chk("w_odd",   32'(w_m_odd),   32'(24'h800000));
        chk("w_last",  32'(w_m_last),  32'(1));
        chk("w_pad",   32'(w_m_pad),   32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
